regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file for the CPU datapath, the next generation of the 16x16 two-read/one-write register file. Adds configurable width, depth and port counts, asynchronous reset of register contents, same-cycle write-to-read bypass, and a per-register busy scoreboard. Decode uses the scoreboard to stall on outstanding producers. Sits between decode (read and allocate) and writeback (write).

## Interface
- DATA_W, 16, register width in bits
- DEPTH, 16, number of registers; power of two, at least 2
- NRD, 2, number of read ports, 1 to 4
- NWR, 1, number of write ports, 1 to 2
- ADDR_W, $clog2(DEPTH), derived localparam; not overridable

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- raddr  in  NRD*ADDR_W  read addresses; port i occupies slice i
- rdata  out  NRD*DATA_W  read data, combinational
- rready  out  NRD  read port i is not busy, or is satisfied by bypass this cycle
- wen  in  NWR  write enables
- waddr  in  NWR*ADDR_W  write addresses
- wdata  in  NWR*DATA_W  write data
- alloc_en  in  1  mark alloc_addr busy (instruction issued, result pending)
- alloc_addr  in  ADDR_W  register being allocated
- busy  out  DEPTH  scoreboard bit per register, registered
- wr_conflict  out  1  registered one-cycle pulse: two write ports hit the same address

## Operation
- Array: DEPTH x DATA_W flops.
  - On a clk edge, each port with wen[j]=1 writes wdata[j] to waddr[j].
  - When two write ports target the same address in one cycle, the higher-indexed port wins.
  - In that same case, wr_conflict is 1 for the following cycle only.
- Read, per port i:
  - If any wen[j]=1 with waddr[j]==raddr[i], rdata[i] = wdata of the highest such j (bypass).
  - Otherwise rdata[i] = array[raddr[i]].
- Scoreboard, updated on each clk edge:
  - Bit for waddr[j] clears when wen[j]=1.
  - Bit for alloc_addr sets when alloc_en=1.
  - Set has priority over clear when both target the same address; the data is still written.
- rready[i] = !busy[raddr[i]] || (any wen[j]=1 with waddr[j]==raddr[i]).
- Allocating an already-busy register keeps it busy; no error is raised.
- Writing a non-busy register is legal. Data is written and busy stays 0.

## Timing
- Reset (rst_n=0, asynchronous): all registers = 0, busy = all 0, wr_conflict = 0.
  - rdata during reset reflects the zeroed array, or bypass if wen is asserted.
  - Writes and allocs are ignored while rst_n=0.
- Reset deassertion is assumed synchronised externally. The first active edge after release is a normal cycle.
- Read latency: 0 cycles (combinational), from either the array or the bypass.
- Write latency: data lands in the array at the edge ending the write cycle. It is visible via bypass in that same cycle.
- busy latency:
  - Set visible the cycle after alloc_en.
  - Clear visible the cycle after wen.
  - rready reflects a write in the same cycle through the bypass term.
- wr_conflict asserts exactly one cycle after the conflicting writes. Back-to-back conflicts hold it high.
- Reset asserted mid-operation discards pending busy state and any in-flight write.

## Configuration
- REGFILE_ZERO_REG_EN defined:
  - Register 0 is hardwired: reads return 0 and writes to address 0 are dropped.
  - Address-0 writes produce no bypass and do not count toward wr_conflict.
  - alloc_addr==0 is ignored; busy[0] is constant 0 and rready is 1 for address 0.
- REGFILE_ZERO_REG_EN undefined: register 0 is an ordinary register.

## Structure
- regfile_pkg holds:
  - default DATA_W, DEPTH, NRD and NWR
  - a clog2-based address-width function
  - typedefs for the data word and register address
- Sub-module regfile_scoreboard holds the busy vector, the set/clear priority logic and the rready generation. The top holds the array, the bypass mux and conflict detection.

## Test plan
- Reset, then read all 16 addresses on both ports -> every rdata = 0x0000; busy = 0; wr_conflict = 0.
- Write 0xBEEF to r5 while reading r5 in the same cycle:
  - rdata = 0xBEEF that cycle (bypass).
  - The next cycle, with wen=0, rdata = 0xBEEF from the array.
- Alloc r3 -> busy[3]=1 and rready=0 next cycle.
  - Write 0x1234 to r3 -> rready=1 in the write cycle, busy[3]=0 the cycle after.
  - Alloc and write r3 in one cycle -> busy[3] stays 1 and array r3 = 0x1234.
- NWR=2: port0 writes 0x1111 and port1 writes 0x2222 to r7 in one cycle:
  - Same-cycle read = 0x2222.
  - Array r7 = 0x2222 afterwards.
  - wr_conflict = 1 for exactly one cycle.
- Pulse rst_n low mid-cycle, asynchronously to clk, with r2 = 0xAAAA and busy[2]=1 -> r2 = 0 and busy[2]=0 immediately, before the next edge.
- With REGFILE_ZERO_REG_EN: write 0xFFFF to r0 and alloc r0 -> reads of r0 = 0, busy[0]=0, rready=1.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// regfile_pkg: default geometry, address-width helper and word/address types for regfile_mp.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_NRD    = 2;
  localparam int DEF_NWR    = 1;

  // A depth of 2 still needs one address bit.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef logic [DEF_DATA_W-1:0]            data_t;
  typedef logic [addr_width(DEF_DEPTH)-1:0] addr_t;

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// regfile_mp_if: read/write/allocate bus between decode/writeback (master) and regfile_mp (slave).
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR
) ();
  localparam int ADDR_W = addr_width(DEPTH);

  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rready;
  logic [NWR-1:0]        wen;
  logic [NWR*ADDR_W-1:0] waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic                  alloc_en;
  logic [ADDR_W-1:0]     alloc_addr;
  logic [DEPTH-1:0]      busy;
  logic                  wr_conflict;

  modport master (
    output raddr, wen, waddr, wdata, alloc_en, alloc_addr,
    input  rdata, rready, busy, wr_conflict
  );

  modport slave (
    input  raddr, wen, waddr, wdata, alloc_en, alloc_addr,
    output rdata, rready, busy, wr_conflict
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// regfile_scoreboard: per-register busy bits (alloc sets, write clears, set wins) and rready.
// REGFILE_ZERO_REG_EN pins busy[0] to 0.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR,
  parameter int ADDR_W = addr_width(DEF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NWR-1:0]        i_wen,
  input  logic [NWR*ADDR_W-1:0] i_waddr,
  input  logic                  i_alloc_en,
  input  logic [ADDR_W-1:0]     i_alloc_addr,
  input  logic [NRD*ADDR_W-1:0] i_raddr,
  input  logic [NRD-1:0]        i_hit,
  output logic [DEPTH-1:0]      o_busy,
  output logic [NRD-1:0]        o_rready
);
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [NRD-1:0]   w_rready;

  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWR; j++) begin
      if (i_wen[j]) w_busy_nxt[i_waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (i_alloc_en) w_busy_nxt[i_alloc_addr] = 1'b1;
`ifdef REGFILE_ZERO_REG_EN
    w_busy_nxt[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // A same-cycle write to the read address satisfies the reader even if still marked busy.
  always_comb begin
    w_rready = '0;
    for (int i = 0; i < NRD; i++) begin
      w_rready[i] = !r_busy[i_raddr[i*ADDR_W +: ADDR_W]] || i_hit[i];
    end
  end

  assign o_busy   = r_busy;
  assign o_rready = w_rready;
endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// regfile_mp: multi-port register file with write-to-read bypass, busy scoreboard and write-conflict flag.
// REGFILE_ZERO_REG_EN hardwires register 0 to zero. Parameters must match those of the bus instance.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);
  localparam int ADDR_W = addr_width(DEPTH);

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic                  r_wr_conflict;
  logic [NWR-1:0]        w_wen;
  logic [NRD-1:0]        w_hit;
  logic [NRD*DATA_W-1:0] w_rdata;
  logic                  w_conflict;

  // Address-0 writes vanish entirely when register 0 is hardwired.
  always_comb begin
    w_wen = '0;
    for (int j = 0; j < NWR; j++) begin
`ifdef REGFILE_ZERO_REG_EN
      w_wen[j] = bus.wen[j] && (bus.waddr[j*ADDR_W +: ADDR_W] != '0);
`else
      w_wen[j] = bus.wen[j];
`endif
    end
  end

  // Later ports overwrite earlier ones, so the highest-indexed writer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (w_wen[j]) r_mem[bus.waddr[j*ADDR_W +: ADDR_W]] <= bus.wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    w_hit   = '0;
    for (int i = 0; i < NRD; i++) begin
      w_rdata[i*DATA_W +: DATA_W] = r_mem[bus.raddr[i*ADDR_W +: ADDR_W]];
      for (int j = 0; j < NWR; j++) begin
        if (w_wen[j] && (bus.waddr[j*ADDR_W +: ADDR_W] == bus.raddr[i*ADDR_W +: ADDR_W])) begin
          w_rdata[i*DATA_W +: DATA_W] = bus.wdata[j*DATA_W +: DATA_W];
          w_hit[i]                    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      for (int k = j + 1; k < NWR; k++) begin
        if (w_wen[j] && w_wen[k] &&
            (bus.waddr[j*ADDR_W +: ADDR_W] == bus.waddr[k*ADDR_W +: ADDR_W]))
          w_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wr_conflict <= 1'b0;
    else        r_wr_conflict <= w_conflict;
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .NRD    (NRD),
    .NWR    (NWR),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wen        (w_wen),
    .i_waddr      (bus.waddr),
    .i_alloc_en   (bus.alloc_en),
    .i_alloc_addr (bus.alloc_addr),
    .i_raddr      (bus.raddr),
    .i_hit        (w_hit),
    .o_busy       (bus.busy),
    .o_rready     (bus.rready)
  );

  assign bus.rdata       = w_rdata;
  assign bus.wr_conflict = r_wr_conflict;
endmodule
`default_nettype wire
